// File: rtl/stream_swapper.sv
// -----------------------------------------------------------------------------
// stream_swapper
//
// Avalon-ST byte/halfword reordering stage with a 2-entry output buffer and a
// small Avalon-MM CSR block.
//
// Reordering modes (ctrl[1:0]), latched per packet on the accepted SOP beat:
//   0 pass-through
//   1 reverse all bytes of the beat
//   2 swap the two bytes inside every 16-bit halfword
//   3 reverse the order of 16-bit halfwords (bytes inside a halfword kept)
//
// Optional feature macro: STREAM_SWAPPER_STATS_EN
//   defined   -> packet_count, beat_count and error_count exist; ctrl[8]
//                (clear_stats) zeroes all three.
//   undefined -> counters are not built and read back as 0.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   stream_in_*                     sink side (data, empty, valid, sop, eop, ready)
//   stream_out_*                    source side (data, empty, valid, sop, eop, ready)
//   csr_address/read/write/
//   csr_writedata                   CSR request, always accepted (no waitrequest)
//   csr_readdata/readdatavalid      CSR response, one cycle after csr_read
//
// CSR map
//   0 ctrl          [1:0] mode (R/W), [8] clear_stats (write-1 pulse, reads 0)
//   1 packet_count  output-side EOP handshakes, wraps
//   2 beat_count    output-side handshakes, wraps
//   3 status        [0] in_packet, [2:1] active mode, [31:16] error_count (sat)
// -----------------------------------------------------------------------------
module stream_swapper #(
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = $clog2(DATA_BYTES)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [DATA_BYTES*8-1:0] stream_in_data,
  input  logic [EMPTY_W-1:0]      stream_in_empty,
  input  logic                    stream_in_valid,
  input  logic                    stream_in_startofpacket,
  input  logic                    stream_in_endofpacket,
  output logic                    stream_in_ready,

  output logic [DATA_BYTES*8-1:0] stream_out_data,
  output logic [EMPTY_W-1:0]      stream_out_empty,
  output logic                    stream_out_valid,
  output logic                    stream_out_startofpacket,
  output logic                    stream_out_endofpacket,
  input  logic                    stream_out_ready,

  input  logic [1:0]              csr_address,
  input  logic                    csr_read,
  input  logic                    csr_write,
  input  logic [31:0]             csr_writedata,
  output logic [31:0]             csr_readdata,
  output logic                    csr_readdatavalid
);

  localparam int DW = DATA_BYTES * 8;
  localparam int HW = DATA_BYTES / 2;
  // Buffered beat layout: {eop, sop, empty, data}
  localparam int BW = DW + EMPTY_W + 2;

  // ---------------------------------------------------------------------------
  // Reordering function. Mode 3 with a single halfword degenerates to identity
  // on its own, so no special case is needed for DATA_BYTES == 2.
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] reorder(input logic [DW-1:0] d,
                                            input logic [1:0]    m);
    logic [DW-1:0] r;
    r = d;
    for (int b = 0; b < DATA_BYTES; b++) begin
      case (m)
        2'd1:    r[b*8 +: 8] = d[(DATA_BYTES-1-b)*8 +: 8];
        2'd2:    r[b*8 +: 8] = d[(b ^ 1)*8 +: 8];
        2'd3:    r[b*8 +: 8] = d[((HW-1-(b/2))*2 + (b%2))*8 +: 8];
        default: r[b*8 +: 8] = d[b*8 +: 8];
      endcase
    end
    return r;
  endfunction

  // Control state
  logic [1:0]    r_ctrl_mode;   // mode written through CSR
  logic [1:0]    r_mode;        // mode latched for the current packet
  logic          r_in_packet;

  // Output buffer
  logic [1:0]    r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [BW-1:0] r_head;
  logic [BW-1:0] r_tail;

  // CSR response
  logic [31:0]   r_rdata;
  logic          r_rvalid;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_sel_mode;
  logic [DW-1:0] w_in_data;
  logic [BW-1:0] w_new;
  logic [1:0]    w_cnt_next;
  logic          w_err;
  logic          w_ctrl_wr;
  logic [31:0]   w_pkt_cnt;
  logic [31:0]   w_beat_cnt;
  logic [15:0]   w_err_cnt;

  assign w_push = stream_in_valid && r_in_ready;
  assign w_pop  = r_out_valid && stream_out_ready;

  // An SOP beat uses the CSR mode directly, so the packet's first beat is
  // already transformed with the mode that is being latched for it.
  assign w_sel_mode = stream_in_startofpacket ? r_ctrl_mode : r_mode;
  assign w_in_data  = reorder(stream_in_data, w_sel_mode);
  assign w_new      = {stream_in_endofpacket, stream_in_startofpacket,
                       stream_in_empty, w_in_data};

  // Protocol error: SOP inside a packet, or a non-SOP beat outside one.
  assign w_err = w_push &&
                 (stream_in_startofpacket ? r_in_packet : !r_in_packet);

  assign w_ctrl_wr = csr_write && (csr_address == 2'd0);

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_push && !w_pop)      w_cnt_next = r_cnt + 2'd1;
    else if (!w_push && w_pop) w_cnt_next = r_cnt - 2'd1;
  end

  // ---- stage: input accept / mode and packet tracking ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_mode <= 2'd0;
      r_mode      <= 2'd0;
      r_in_packet <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ctrl_mode <= csr_writedata[1:0];
      if (w_push) begin
        if (stream_in_startofpacket) begin
          r_mode      <= r_ctrl_mode;
          r_in_packet <= !stream_in_endofpacket;
        end else if (stream_in_endofpacket) begin
          r_in_packet <= 1'b0;
        end
      end
    end
  end

  // ---- stage: 2-entry output buffer (head drives stream_out_*) ----
  // Ready is registered from the next occupancy, so a push while full can
  // never happen and the head only changes on a pop or into an empty buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_in_ready  <= (w_cnt_next < 2'd2);
      r_out_valid <= (w_cnt_next != 2'd0);
      if (w_pop) begin
        if (r_cnt == 2'd2) r_head <= r_tail;
        else if (w_push)   r_head <= w_new;
      end else if (w_push && (r_cnt == 2'd0)) begin
        r_head <= w_new;
      end
    end
  end

  // Second slot holds data only; its contents are meaningless unless r_cnt==2.
  always_ff @(posedge clk) begin
    if (w_push && !w_pop && (r_cnt == 2'd1)) r_tail <= w_new;
  end

  assign stream_in_ready          = r_in_ready;
  assign stream_out_valid         = r_out_valid;
  assign stream_out_data          = r_head[DW-1:0];
  assign stream_out_empty         = r_head[DW +: EMPTY_W];
  assign stream_out_startofpacket = r_head[DW+EMPTY_W];
  assign stream_out_endofpacket   = r_head[DW+EMPTY_W+1];

  // ---- stage: statistics ----
`ifdef STREAM_SWAPPER_STATS_EN
  logic        w_clear;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_beat_cnt;
  logic [15:0] r_err_cnt;

  assign w_clear = w_ctrl_wr && csr_writedata[8];

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_pkt_cnt  <= 32'd0;
      r_beat_cnt <= 32'd0;
      r_err_cnt  <= 16'd0;
    end else begin
      if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
      if (w_pop && stream_out_endofpacket) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign w_pkt_cnt  = r_pkt_cnt;
  assign w_beat_cnt = r_beat_cnt;
  assign w_err_cnt  = r_err_cnt;
`else
  assign w_pkt_cnt  = 32'd0;
  assign w_beat_cnt = 32'd0;
  assign w_err_cnt  = 16'd0;
`endif

  // Bits of the write bus with no register behind them, plus the error
  // strobe when statistics are not built.
  logic w_unused;
  assign w_unused = ^{csr_writedata[31:9], csr_writedata[7:2], w_err};

  // ---- stage: CSR read response ----
  // Reads sample register state before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= csr_read;
      r_rdata  <= 32'd0;
      if (csr_read) begin
        case (csr_address)
          2'd0:    r_rdata <= {30'd0, r_ctrl_mode};
          2'd1:    r_rdata <= w_pkt_cnt;
          2'd2:    r_rdata <= w_beat_cnt;
          default: r_rdata <= {w_err_cnt, 13'd0, r_mode, r_in_packet};
        endcase
      end
    end
  end

  assign csr_readdata      = r_rdata;
  assign csr_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_stream_swapper.sv
`timescale 1ns/1ps
module tb_stream_swapper;
  localparam int DB = 8;
  localparam int DW = DB * 8;
  localparam int EW = 3;
  localparam int BW = DW + EW + 2;
`ifdef STREAM_SWAPPER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] stream_in_data;
  logic [EW-1:0] stream_in_empty;
  logic          stream_in_valid;
  logic          stream_in_startofpacket;
  logic          stream_in_endofpacket;
  logic          stream_in_ready;
  logic [DW-1:0] stream_out_data;
  logic [EW-1:0] stream_out_empty;
  logic          stream_out_valid;
  logic          stream_out_startofpacket;
  logic          stream_out_endofpacket;
  logic          stream_out_ready;
  logic [1:0]    csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic          csr_readdatavalid;

  always #5 clk = ~clk;

  stream_swapper #(.DATA_BYTES(DB)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_ready          (stream_in_ready),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_ready         (stream_out_ready),
    .csr_address              (csr_address),
    .csr_read                 (csr_read),
    .csr_write                (csr_write),
    .csr_writedata            (csr_writedata),
    .csr_readdata             (csr_readdata),
    .csr_readdatavalid        (csr_readdatavalid)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [BW-1:0] exp_q[$];
  int m_ctrl, m_mode, m_err, m_pkts, m_beats;
  bit m_inpkt;
  bit rnd_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reordering described as byte/halfword sequences rather than bit indices.
  function automatic logic [DW-1:0] ref_reorder(input logic [DW-1:0] d, input int mode);
    logic [7:0]    bq[$];
    logic [15:0]   hq[$];
    logic [DW-1:0] r;
    r = d;
    case (mode)
      1: begin
        for (int i = 0; i < DB; i++) bq.push_front(d[i*8 +: 8]);
        for (int i = 0; i < DB; i++) r[i*8 +: 8] = bq[i];
      end
      2: for (int i = 0; i < DB/2; i++) r[i*16 +: 16] = {d[i*16 +: 8], d[i*16+8 +: 8]};
      3: begin
        for (int i = 0; i < DB/2; i++) hq.push_front(d[i*16 +: 16]);
        for (int i = 0; i < DB/2; i++) r[i*16 +: 16] = hq[i];
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [15:0] e;
    e = STATS ? m_err[15:0] : 16'd0;
    return {e, 13'd0, m_mode[1:0], m_inpkt};
  endfunction

  function automatic logic [31:0] exp_pkts();
    return STATS ? 32'(m_pkts) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_beats();
    return STATS ? 32'(m_beats) : 32'd0;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic [EW-1:0] e,
                              input bit s, input bit eo);
    int md;
    md = s ? m_ctrl : m_mode;
    if (s) m_mode = m_ctrl;
    if ((s && m_inpkt) || (!s && !m_inpkt))
      if (m_err < 65535) m_err++;
    if (s) m_inpkt = !eo;
    else if (eo) m_inpkt = 1'b0;
    exp_q.push_back({eo, s, e, ref_reorder(d, md)});
  endtask

  // Drive one beat; returns at posedge+1 after it was accepted.
  task automatic send(input logic [DW-1:0] d, input logic [EW-1:0] e, input bit s, input bit eo);
    int n;
    stream_in_data = d; stream_in_empty = e;
    stream_in_startofpacket = s; stream_in_endofpacket = eo;
    stream_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!stream_in_ready && n < 100) begin @(negedge clk); n++; end
    if (!stream_in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
    end else begin
      model_accept(d, e, s, eo);
    end
    @(posedge clk); #1;
    stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0;
    stream_in_endofpacket = 1'b0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
    if (a == 2'd0) begin
      m_ctrl = int'(d[1:0]);
      if (STATS && d[8]) begin m_pkts = 0; m_beats = 0; m_err = 0; end
    end
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    chk({name, "_rdv"}, csr_readdatavalid, 1'b1);
    chk(name, csr_readdata, exp);
    @(posedge clk); #1;
    chk({name, "_rdv_off"}, csr_readdatavalid, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stream_out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled output holds still.
  logic [BW-1:0] cur_out, prev_out;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    cur_out = {stream_out_endofpacket, stream_out_startofpacket, stream_out_empty, stream_out_data};
    if (!reset) begin
      if (prev_stall) chk("out_stable", cur_out, prev_out);
      if (stream_out_valid && stream_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got beat 0x%0h expected none", cur_out);
        end else begin
          chk("out_beat", cur_out, exp_q.pop_front());
        end
        m_beats++;
        if (stream_out_endofpacket) m_pkts++;
      end
      prev_stall = stream_out_valid && !stream_out_ready;
    end else begin
      prev_stall = 1'b0;
    end
    prev_out = cur_out;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] tv;
    tv = 64'h0807060504030201;
    reset = 1'b1;
    stream_in_data = '0; stream_in_empty = '0; stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
    stream_out_ready = 1'b1;
    csr_address = 2'd0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = 32'd0;
    m_ctrl = 0; m_mode = 0; m_err = 0; m_pkts = 0; m_beats = 0; m_inpkt = 1'b0;
    rnd_done = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", stream_in_ready, 1'b0);
    chk("rst_out_valid", stream_out_valid, 1'b0);
    chk("rst_out_data", {stream_out_endofpacket, stream_out_startofpacket, stream_out_empty, stream_out_data}, '0);
    chk("rst_rdv", csr_readdatavalid, 1'b0);
    chk("rst_rdata", csr_readdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", stream_in_ready, 1'b1);
    csr_rd(2'd3, 32'd0, "rst_status");
    csr_rd(2'd0, 32'd0, "rst_ctrl");

    // Single-beat packets in modes 1..3, with one-cycle latency.
    csr_wr(2'd0, 32'd1);
    send(tv, 3'd0, 1'b1, 1'b1);
    chk("lat_valid_m1", stream_out_valid, 1'b1);
    chk("data_m1", stream_out_data, 64'h0102030405060708);
    drain();
    csr_rd(2'd1, exp_pkts(), "pkt_count_1");
    csr_wr(2'd0, 32'd2);
    send(tv, 3'd5, 1'b1, 1'b1);
    chk("data_m2", stream_out_data, 64'h0708050603040102);
    drain();
    csr_wr(2'd0, 32'd3);
    send(tv, 3'd2, 1'b1, 1'b1);
    chk("data_m3", stream_out_data, 64'h0201040306050807);
    drain();
    csr_rd(2'd0, 32'd3, "ctrl_rb");

    // Mode write mid-packet does not affect the current packet.
    csr_wr(2'd0, 32'd0);
    send(tv, 3'd0, 1'b1, 1'b0);
    csr_wr(2'd0, 32'd1);
    send(tv + 64'h1111, 3'd0, 1'b0, 1'b0);
    send(tv + 64'h2222, 3'd0, 1'b0, 1'b0);
    send(tv + 64'h3333, 3'd4, 1'b0, 1'b1);
    send(tv, 3'd0, 1'b1, 1'b0);
    csr_rd(2'd3, exp_status(), "status_new_pkt");
    send(tv, 3'd1, 1'b0, 1'b1);
    drain();

    // Backpressure: two beats absorbed, third held off, then 1 beat/cycle.
    csr_wr(2'd0, 32'h102);
    stream_out_ready = 1'b0;
    send(64'hA1, 3'd0, 1'b1, 1'b0);
    send(64'hA2, 3'd0, 1'b0, 1'b0);
    chk("bp_ready_low", stream_in_ready, 1'b0);
    chk("bp_out_valid", stream_out_valid, 1'b1);
    fork
      send(64'hA3, 3'd0, 1'b0, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_still_low", stream_in_ready, 1'b0);
        stream_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_throughput_valid", stream_out_valid, 1'b1);
        end
      end
    join
    drain();
    csr_rd(2'd2, exp_beats(), "beat_count_bp");

    // Protocol error: SOP, SOP, EOP.
    send(64'hB1, 3'd0, 1'b1, 1'b0);
    send(64'hB2, 3'd0, 1'b1, 1'b0);
    send(64'hB3, 3'd0, 1'b0, 1'b1);
    drain();
    csr_rd(2'd3, exp_status(), "status_err");
    csr_rd(2'd2, exp_beats(), "beat_count_err");
    csr_wr(2'd0, 32'h102);
    csr_rd(2'd1, exp_pkts(), "pkt_after_clr");
    csr_rd(2'd2, exp_beats(), "beat_after_clr");
    csr_rd(2'd3, exp_status(), "status_after_clr");

    // Randomized traffic with random backpressure and mode changes.
    fork
      begin
        bit inp;
        inp = 1'b0;
        for (int i = 0; i < 300; i++) begin
          bit s, eo;
          if ($urandom_range(9) == 0) csr_wr(2'd0, 32'($urandom_range(3)));
          s  = inp ? ($urandom_range(19) == 0) : ($urandom_range(19) != 0);
          eo = ($urandom_range(9) < 3);
          send({$urandom, $urandom}, 3'($urandom_range(7)), s, eo);
          if (s) inp = !eo; else if (eo) inp = 1'b0;
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          if (!rnd_done) stream_out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    stream_out_ready = 1'b1;
    drain();
    csr_rd(2'd1, exp_pkts(), "pkt_count_rnd");
    csr_rd(2'd2, exp_beats(), "beat_count_rnd");
    csr_rd(2'd3, exp_status(), "status_rnd");

    // Reset with two beats buffered mid-packet.
    csr_wr(2'd0, 32'd1);
    stream_out_ready = 1'b0;
    send(64'hC1, 3'd0, 1'b1, 1'b0);
    send(64'hC2, 3'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("flush_out_valid", stream_out_valid, 1'b0);
    chk("flush_in_ready", stream_in_ready, 1'b0);
    exp_q.delete();
    m_ctrl = 0; m_mode = 0; m_err = 0; m_pkts = 0; m_beats = 0; m_inpkt = 1'b0;
    reset = 1'b0;
    stream_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_ready_after", stream_in_ready, 1'b1);
    csr_rd(2'd1, 32'd0, "pkt_after_rst");
    csr_rd(2'd2, 32'd0, "beat_after_rst");
    csr_rd(2'd3, 32'd0, "status_after_rst");
    send(tv, 3'd0, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_swapper.md
# stream_swapper

Parametrised successor to the fixed 64-bit endian swapper. It sits on an Avalon-ST datapath between two streaming components and applies one of four selectable byte/halfword reordering modes per packet. Full ready/valid backpressure comes from a 2-entry output buffer. A 4-register Avalon-MM CSR bus provides control and optional statistics.

## Interface
Parameters:
- DATA_BYTES, 8, stream width in bytes; power of two, 2..64.
- EMPTY_W, $clog2(DATA_BYTES), width of the empty field (derived, not overridden).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset, sampled on clk.
- stream_in_data  in  DATA_BYTES*8  input beat; byte 0 at [7:0].
- stream_in_empty  in  EMPTY_W  unused bytes on EOP beat.
- stream_in_valid  in  1  beat present.
- stream_in_startofpacket  in  1  first beat of packet.
- stream_in_endofpacket  in  1  last beat of packet.
- stream_in_ready  out  1  registered; block can accept a beat.
- stream_out_data  out  DATA_BYTES*8  reordered beat.
- stream_out_empty  out  EMPTY_W  passed through unchanged.
- stream_out_valid  out  1  beat present.
- stream_out_startofpacket  out  1  first beat.
- stream_out_endofpacket  out  1  last beat.
- stream_out_ready  in  1  sink accepts beat.
- csr_address  in  2  register select.
- csr_read  in  1  read strobe.
- csr_write  in  1  write strobe.
- csr_writedata  in  32  write data.
- csr_readdata  out  32  read data.
- csr_readdatavalid  out  1  read data valid.

## Operation
- Modes (CSR ctrl[1:0]): 0 pass-through; 1 reverse all bytes of the word; 2 swap bytes within each 16-bit halfword; 3 reverse the order of 16-bit halfwords, keeping byte order inside each. Mode 3 with DATA_BYTES==2 behaves as mode 0.
- Input accepted when stream_in_valid && stream_in_ready. The transform is applied at accept; the beat is written into a 2-entry FIFO together with empty, SOP and EOP.
- Active mode is latched from ctrl[1:0] on each accepted SOP beat and held until the next accepted SOP. A CSR mode write mid-packet never affects the current packet.
- The output side presents the FIFO head. A beat leaves on stream_out_valid && stream_out_ready.
- stream_in_ready next = (occupancy after this cycle < 2). Simultaneous push and pop when full is not possible, because ready is 0 when full.
- Protocol tracking: in_packet is set on an accepted SOP and cleared on an accepted EOP. A single-beat packet (SOP and EOP together) leaves in_packet at 0.
  - Accepted SOP while in_packet = 1 counts as an error.
  - Accepted non-SOP beat while in_packet = 0 counts as an error.
  - Error beats are still forwarded. A non-SOP beat outside a packet uses the last latched mode.
- CSR map:
  - 0 ctrl, R/W: [1:0] mode, reset 0. [8] clear_stats, write-1 pulse, reads 0.
  - 1 packet_count, RO: output-side EOP handshakes; 32-bit, wraps.
  - 2 beat_count, RO: output-side handshakes; 32-bit, wraps.
  - 3 status, RO: [0] in_packet; [2:1] active mode; [31:16] error_count, saturating at 0xFFFF.
- Reads to 1, 2 and status[31:16] return 0 when statistics are compiled out.
- CSR has no waitrequest; it is always ready.
- Counter clear and increment in the same cycle: the clear wins, and the counter is 0.

## Timing
- Reset values:
  - stream_in_ready = 0.
  - stream_out_valid = 0; stream_out_data, empty, SOP and EOP = 0.
  - csr_readdata = 0; csr_readdatavalid = 0.
  - mode, in_packet, FIFO occupancy and all counters = 0.
- First cycle after reset deasserts: stream_in_ready = 1.
- Latency: a beat accepted in cycle N appears on stream_out_* in cycle N+1 when the FIFO was empty.
- Throughput: 1 beat/cycle while stream_out_ready is held high.
- Backpressure: with stream_out_ready = 0, two beats are absorbed and stream_in_ready drops in the cycle after the second accept.
- Output stability: while stream_out_valid = 1 and stream_out_ready = 0, all stream_out_* hold stable.
- CSR read: csr_read in cycle N gives csr_readdatavalid = 1 with data in cycle N+1, for exactly one cycle.
- Read and write in the same cycle: the write takes effect, and the read returns the pre-write value.
- Reset asserted mid-packet: the FIFO is flushed, in_packet is cleared, and partial beats are discarded without counting.

## Configuration
- STREAM_SWAPPER_STATS_EN defined: packet_count, beat_count and error_count are implemented, and clear_stats is functional.
- Not defined: the counters are not synthesised, their register reads return 0, and clear_stats has no effect. Datapath, modes, in_packet and active-mode status are unaffected.

## Test plan
- DATA_BYTES=8, mode 1, single beat 0x0807060504030201 SOP+EOP → out 0x0102030405060708 at N+1; packet_count = 1.
- Mode 2, data 0x0807060504030201 → 0x0708050603040102. Mode 3, same data → 0x0201040306050807.
- Write mode 1 mid 4-beat packet started in mode 0 → all 4 beats pass through unchanged; the next packet is reversed; status[2:1] = 1 after its SOP.
- Hold stream_out_ready = 0 and drive 3 beats → 2 accepted, stream_in_ready = 0, outputs stable. Release → beats in order, 1 per cycle, beat_count = 3.
- SOP, SOP, EOP sequence → error_count = 1 and 3 beats forwarded. Write ctrl[8] = 1 → all counters read 0 next read.
- Assert reset with 2 beats buffered → stream_out_valid = 0 next cycle; stream_in_ready = 1 the cycle after release; counters are 0.
